// File: rtl/brush_stamper.sv
// Radius-2 diamond brush stamper: walks 13 offsets around a latched centre,
// clips each point to the screen and issues in-bounds points as valid/ready writes.
module brush_stamper #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int COLOR_W  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic signed [15:0] cx,
    input  logic signed [15:0] cy,
    input  logic [COLOR_W-1:0] color,
    input  logic               abort,
    output logic               busy,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [15:0]        wr_x,
    output logic [15:0]        wr_y,
    output logic [COLOR_W-1:0] wr_color,
    output logic               done,
    output logic [3:0]         n_written
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STAMP,
        ST_DONE
    } state_e;

    localparam logic signed [15:0] W_LIM    = 16'(SCREEN_W);
    localparam logic signed [15:0] H_LIM    = 16'(SCREEN_H);
    localparam logic [3:0]         LAST_IDX = 4'd12;

    state_e               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic signed [15:0]   cx_q, cx_d, cy_q, cy_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [3:0]           n_q, n_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic [15:0]          x_q, x_d, y_q, y_d;
    logic signed [15:0]   px, py;
    logic                 in_bounds;

    // Diamond offsets in raster order, top row first.
    function automatic logic signed [15:0] off_dx(input logic [3:0] i);
        case (i)
            4'd1, 4'd5, 4'd9:  off_dx = -16'sd1;
            4'd3, 4'd7, 4'd11: off_dx = 16'sd1;
            4'd4:              off_dx = -16'sd2;
            4'd8:              off_dx = 16'sd2;
            default:           off_dx = 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] off_dy(input logic [3:0] i);
        case (i)
            4'd0:                   off_dy = -16'sd2;
            4'd1, 4'd2, 4'd3:       off_dy = -16'sd1;
            4'd9, 4'd10, 4'd11:     off_dy = 16'sd1;
            4'd12:                  off_dy = 16'sd2;
            default:                off_dy = 16'sd0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        color_d = color_q;
        n_d     = n_q;
        x_d     = x_q;
        y_d     = y_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    color_d = color;
                    idx_d   = 4'd0;
                    n_d     = 4'd0;
                    state_d = ST_STAMP;
                end
            end
            ST_STAMP: begin
                // A handshake on the abort cycle still counts as written.
                if (valid_q && wr_ready) n_d = n_q + 4'd1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!valid_q || wr_ready) begin
                    if (idx_q == LAST_IDX) state_d = ST_DONE;
                    else                   idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Point for the next cycle, so wr_valid is registered yet valid on STAMP entry.
        px        = cx_d + off_dx(idx_d);
        py        = cy_d + off_dy(idx_d);
        in_bounds = (px >= 16'sd0) && (px < W_LIM) && (py >= 16'sd0) && (py < H_LIM);
        valid_d   = (state_d == ST_STAMP) && in_bounds;
        if (valid_d) begin
            x_d = px;
            y_d = py;
        end
        done_d = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            color_q <= color_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign wr_valid  = valid_q;
    assign wr_x      = x_q;
    assign wr_y      = y_q;
    assign wr_color  = color_q;
    assign done      = done_q;
    assign n_written = n_q;

endmodule

// File: tb/tb_brush_stamper.sv
// Scoreboard bench for brush_stamper: expected writes are queued at start and
// compared in order as handshakes occur.
module tb_brush_stamper;

    localparam int W  = 320;
    localparam int H  = 240;
    localparam int CW = 8;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          wr_ready = 1'b1;
    logic [15:0]   cx       = '0;
    logic [15:0]   cy       = '0;
    logic [CW-1:0] color    = '0;
    logic          busy, wr_valid, done;
    logic [15:0]   wr_x, wr_y;
    logic [CW-1:0] wr_color;
    logic [3:0]    n_written;

    brush_stamper #(.SCREEN_W(W), .SCREEN_H(H), .COLOR_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .cx(cx), .cy(cy),
        .color(color), .abort(abort), .busy(busy), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .done(done), .n_written(n_written)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          x;
        int          y;
        int          idx;
        logic [CW-1:0] c;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  dx_t[13] = '{0, -1, 0, 1, -2, -1, 0, 1, 2, -1, 0, 1, 0};
    int  dy_t[13] = '{-2, -1, -1, -1, 0, 0, 0, 0, 0, 1, 1, 1, 2};

    task automatic push_expected(input int px, input int py, input logic [CW-1:0] c,
                                 output int cnt);
        wr_t e;
        cnt = 0;
        for (int i = 0; i < 13; i++) begin
            e.x = px + dx_t[i];
            e.y = py + dy_t[i];
            e.idx = i;
            e.c = c;
            if (e.x >= 0 && e.x < W && e.y >= 0 && e.y < H) begin
                exp_q.push_back(e);
                cnt++;
            end
        end
    endtask

    // Runs one stamp; returns cycles from STAMP entry to done (-1 if aborted or timed out).
    task automatic run_stamp(input int px, input int py, input logic [CW-1:0] col,
                             input int stall_idx, input int stall_len, input int abort_hs,
                             input bit mid_start, output int done_cyc);
        int  c, hs, stalled, n_exp;
        wr_t e;
        exp_q.delete();
        push_expected(px, py, col, n_exp);
        @(negedge clock);
        start = 1'b1; cx = px[15:0]; cy = py[15:0]; color = col;
        @(negedge clock);
        start = 1'b0; cx = 16'd200; cy = 16'd200; color = ~col;
        c = 0; hs = 0; stalled = 0; done_cyc = -1;
        while (1) begin
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (c > 100) begin
                checks++; errors++;
                $display("FAIL timeout: no done within 100 cycles (n_written=%0d)", n_written);
                break;
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_stamp: cycle %0d got %b want 1", c, busy);
            end
            start    = mid_start && (c == 2);
            wr_ready = 1'b1;
            if (wr_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write: got (%0d,%0d) with no write expected", wr_x, wr_y);
                end else begin
                    e = exp_q[0];
                    if (wr_x !== e.x[15:0] || wr_y !== e.y[15:0] || wr_color !== e.c) begin
                        errors++;
                        $display("FAIL write_%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                                 e.idx, wr_x, wr_y, wr_color, e.x, e.y, e.c);
                    end
                    if (e.idx == stall_idx && stalled < stall_len) begin
                        wr_ready = 1'b0;
                        stalled++;
                    end else begin
                        void'(exp_q.pop_front());
                        hs++;
                        if (hs == abort_hs) begin
                            abort = 1'b1;
                            start = 1'b1;
                        end
                    end
                end
            end
            @(negedge clock);
            c++;
            if (abort) begin
                abort = 1'b0; start = 1'b0;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || n_written !== 4'(hs)) begin
                    errors++;
                    $display("FAIL abort_exit: busy=%b done=%b n_written=%0d want 0 0 %0d",
                             busy, done, n_written, hs);
                end
                repeat (3) begin
                    @(negedge clock);
                    checks++;
                    if (busy !== 1'b0 || done !== 1'b0 || n_written !== 4'(hs)) begin
                        errors++;
                        $display("FAIL abort_idle: busy=%b done=%b n_written=%0d want 0 0 %0d",
                                 busy, done, n_written, hs);
                    end
                end
                exp_q.delete();
                return;
            end
        end
        start = 1'b0;
        wr_ready = 1'b1;
        if (done_cyc >= 0) begin
            checks++;
            if (n_written !== 4'(n_exp) || exp_q.size() != 0) begin
                errors++;
                $display("FAIL stamp_count: n_written=%0d want %0d, %0d writes missing",
                         n_written, n_exp, exp_q.size());
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: after done got done=%b busy=%b want 0 0", done, busy);
            end
        end
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || wr_valid !== 1'b0 || done !== 1'b0 || wr_x !== 16'd0 ||
            wr_y !== 16'd0 || wr_color !== '0 || n_written !== 4'd0) begin
            errors++;
            $display("FAIL %s: busy=%b valid=%b done=%b x=%0d y=%0d color=%h n=%0d want all 0",
                     tag, busy, wr_valid, done, wr_x, wr_y, wr_color, n_written);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        check_all_zero("reset_state");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_centre();
        int dc;
        run_stamp(100, 100, 8'hA5, -1, 0, 0, 1'b0, dc);
        checks++;
        if (dc !== 13) begin
            errors++;
            $display("FAIL centre_latency: got %0d want 13", dc);
        end
    endtask

    task automatic test_origin();
        int dc;
        run_stamp(0, 0, 8'h3C, -1, 0, 0, 1'b0, dc);
        checks++;
        if (dc !== 13) begin
            errors++;
            $display("FAIL origin_latency: got %0d want 13", dc);
        end
    endtask

    task automatic test_far_corner();
        int dc;
        run_stamp(W - 1, H - 1, 8'h5A, -1, 0, 0, 1'b0, dc);
        checks++;
        if (dc !== 13) begin
            errors++;
            $display("FAIL corner_latency: got %0d want 13", dc);
        end
    endtask

    task automatic test_negative();
        int dc;
        run_stamp(-1, -1, 8'h81, -1, 0, 0, 1'b0, dc);
        checks++;
        if (dc !== 13) begin
            errors++;
            $display("FAIL negative_latency: got %0d want 13", dc);
        end
    endtask

    task automatic test_stall();
        int dc;
        run_stamp(50, 50, 8'h77, 4, 3, 0, 1'b0, dc);
        checks++;
        if (dc !== 16) begin
            errors++;
            $display("FAIL stall_latency: got %0d want 16", dc);
        end
    endtask

    task automatic test_abort();
        int dc;
        run_stamp(100, 100, 8'hC3, -1, 0, 5, 1'b1, dc);
        checks++;
        if (dc !== -1) begin
            errors++;
            $display("FAIL abort_done: done seen at cycle %0d want none", dc);
        end
    endtask

    task automatic test_reset_mid_stamp();
        int dc;
        @(negedge clock);
        start = 1'b1; cx = 16'd10; cy = 16'd10; color = 8'hEE;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_stamp");
        @(negedge clock);
        check_all_zero("held_in_reset");
        reset_n = 1'b1;
        run_stamp(10, 10, 8'h42, -1, 0, 0, 1'b0, dc);
        checks++;
        if (dc !== 13) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d want 13", dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        run_stamp(200, 5, 8'h11, -1, 0, 0, 1'b0, dc);
        run_stamp(318, 1, 8'h22, -1, 0, 0, 1'b0, dc);
        checks++;
        if (dc !== 13) begin
            errors++;
            $display("FAIL back_to_back_latency: got %0d want 13", dc);
        end
    endtask

    initial begin
        test_reset();
        test_centre();
        test_origin();
        test_far_corner();
        test_negative();
        test_stall();
        test_abort();
        test_reset_mid_stamp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
